blwl_config_ctrl: RTL
=====================

# blwl_config_ctrl

Memory-bank programming controller directly upstream of the configuration SRAM cell array. It accepts a serial bitstream over a valid/ready handshake and assembles one row of bit-line data at a time. It then pulses the row's word line so every cell in that row captures its bit through WE/D. It walks all rows once per START, then reports DONE.

## Interface
Parameters:
- NUM_BL, 8: bit lines per row (cells per word line), >= 1
- NUM_WL, 4: word lines (rows), >= 1
- WL_PULSE, 2: word-line high time in cycles, >= 1

Ports:
- CLK  in  1  clock; all logic on rising edge
- RSTN  in  1  reset, **synchronous, active-low**
- START  in  1  begin programming; sampled only in IDLE
- DIN  in  1  bitstream bit
- DIN_VALID  in  1  DIN valid
- DIN_READY  out  1  controller accepts DIN this cycle
- BL  out  [0:NUM_BL-1]  bit-line data to cell D inputs
- WL  out  [0:NUM_WL-1]  word lines to cell WE inputs, at most one hot
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse after last row

## Operation
- Reset, with RSTN low at a rising edge, sets all outputs and internal state to 0 and enters IDLE.
- States: IDLE, LOAD, SETUP, PULSE, HOLD, FINISH.
- **IDLE**
  - Outputs are 0, except BL, which holds its last value (0 after reset).
  - START=1 sets the row counter to 0 and the bit counter to 0, and enters LOAD.
- **LOAD**
  - DIN_READY=1.
  - Each beat with DIN_VALID & DIN_READY writes DIN to BL[bitcnt] and increments bitcnt.
  - bitcnt counts 0 to NUM_BL-1; the first bit received goes to BL[0].
  - On the beat where bitcnt==NUM_BL-1, reset bitcnt and go to SETUP if the guard is configured, otherwise to PULSE.
  - DIN_VALID low stalls LOAD indefinitely.
- **SETUP**: one cycle; WL all 0, BL stable, DIN_READY=0.
- **PULSE**
  - WL[row]=1 for exactly WL_PULSE cycles.
  - All other WL bits are 0; BL is stable.
- **HOLD**
  - One cycle with WL all 0 and BL stable.
  - If row==NUM_WL-1, go to FINISH; otherwise increment row and go to LOAD.
- **FINISH**: DONE=1 for one cycle, then IDLE.
- BL changes only in LOAD. WL is never high in LOAD or SETUP, so a cell never sees D change while its WE is high.
- START outside IDLE is ignored; there is no restart mid-sequence.
- DIN_VALID outside LOAD is ignored and no beat is consumed.
- Reset mid-sequence:
  - WL drops to 0 at that edge and the FSM returns to IDLE.
  - Cells already programmed keep their data; the row in flight may be partially written.
  - The next START restarts at row 0.
- Counter widths:
  - row: $clog2(NUM_WL), minimum 1.
  - bitcnt: $clog2(NUM_BL), minimum 1.
  - pulse counter: $clog2(WL_PULSE+1).
  - No counter wraps past its terminal value.
- NUM_WL=1 or NUM_BL=1 must work; with NUM_BL=1, a single beat completes LOAD.

## Timing
- START sampled at edge 0 puts the FSM in LOAD from cycle 1.
- Per row, with no input stalls: NUM_BL + G + WL_PULSE + 1 cycles. G=1 with the guard, 0 without.
- Defaults with the guard:
  - Row r LOAD: cycles 1+12r to 8+12r.
  - SETUP: 9+12r.
  - PULSE: 10+12r and 11+12r.
  - HOLD: 12+12r.
  - DONE: cycle 49.
- Defaults without the guard: DONE at cycle 45.
- Each DIN stall cycle adds exactly one cycle.
- DIN_READY is a registered state decode; it does not depend combinationally on DIN_VALID.
- All outputs are registered.

## Configuration
- BLWL_SETUP_GUARD_EN defined: the SETUP state exists, giving one cycle of BL setup before WL rises.
- Undefined: LOAD goes directly to PULSE. WL rises on the cycle after the last BL bit is written; this relies on the cells' combinational WE/D behaviour.
- HOLD is always present.

## Structure
- Package blwl_config_pkg holds:
  - the state enum (IDLE, LOAD, SETUP, PULSE, HOLD, FINISH);
  - the width helper function, $clog2 with a minimum of 1.
- One sub-module, bl_row_shifter, covers the BL register and the bit counter.
  - Inputs: clear, load beat, DIN.
  - Outputs: BL, last_bit.
- The FSM, row counter, pulse counter and WL decode live in the top module.

## Test plan
- **Reset**: RSTN low for 2 cycles with START=1 → BL=0, WL=0, BUSY=0, DONE=0, DIN_READY=0.
- **Full program, defaults, guard on, no stalls, stream rows 0xA5, 0x3C, 0xFF, 0x01 with bit 0 first**:
  - WL[r] is high exactly at cycles 10+12r and 11+12r.
  - BL equals the row value during those cycles; DONE pulses at cycle 49.
  - A behavioural SRAM array reads back all 32 bits.
- **Same stream, guard off** → WL[r] high at cycles 9+11r and 10+11r; DONE at cycle 45.
- **DIN_VALID deasserted for 5 cycles mid-row 1** → DONE is delayed by exactly 5 cycles and the written data is unchanged.
- **START re-asserted during PULSE, and DIN_VALID held high in HOLD/IDLE** → no restart, no extra beats consumed, one DONE.
- **RSTN low during row 2 PULSE** → WL=0 at the next edge and the FSM is in IDLE; rows 0 and 1 remain programmed. A subsequent START plus full stream completes normally.

Source files
------------

// File: rtl/blwl_config_pkg.sv
// Shared types and helpers for the bit-line/word-line configuration controller.
// Optional feature macro: BLWL_SETUP_GUARD_EN (adds a one-cycle BL setup state before WL rises).
package blwl_config_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSetup,
      StPulse,
      StHold,
      StFinish
   } state_e;

   // Counter width for a count range of n values; never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/blwl_config_ctrl_if.sv
// Serial bitstream valid/ready channel feeding the configuration controller.
interface blwl_config_ctrl_if;

   logic DIN;
   logic DIN_VALID;
   logic DIN_READY;

   modport master (
      output DIN,
      output DIN_VALID,
      input  DIN_READY
   );

   modport slave (
      input  DIN,
      input  DIN_VALID,
      output DIN_READY
   );

endinterface

// File: rtl/bl_row_shifter.sv
// Assembles one row of bit-line data; bit 0 of the row is the first bit received.
module bl_row_shifter
   import blwl_config_pkg::*;
#(
   parameter int unsigned NUM_BL = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              beat_i,
   input  logic              din_i,
   output logic [0:NUM_BL-1] bl_o,
   output logic              last_bit_o
);

   localparam int unsigned BitW = clog2_min1(NUM_BL);

   logic [0:NUM_BL-1] bl_q, bl_d;
   logic [BitW-1:0]   bitcnt_q, bitcnt_d;

   assign last_bit_o = (bitcnt_q == BitW'(NUM_BL - 1));
   assign bl_o       = bl_q;

   // Next-state: write the accepted bit at the current position, wrap the counter after the last.
   always_comb begin
      bl_d     = bl_q;
      bitcnt_d = bitcnt_q;
      if (clear_i) begin
         bitcnt_d = '0;
      end else if (beat_i) begin
         bl_d[bitcnt_q] = din_i;
         bitcnt_d       = last_bit_o ? '0 : bitcnt_q + BitW'(1);
      end
   end

   // Row register and bit counter; BL is only cleared by reset so it holds across IDLE.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bl_q     <= '0;
         bitcnt_q <= '0;
      end else begin
         bl_q     <= bl_d;
         bitcnt_q <= bitcnt_d;
      end
   end

endmodule

// File: rtl/blwl_config_ctrl.sv
// Configuration SRAM programming controller: loads a row of BL data from a serial stream,
// pulses that row's word line, and walks all rows once per START.
// Optional feature macro: BLWL_SETUP_GUARD_EN (one SETUP cycle between LOAD and PULSE).
module blwl_config_ctrl
   import blwl_config_pkg::*;
#(
   parameter int unsigned NUM_BL   = 8,
   parameter int unsigned NUM_WL   = 4,
   parameter int unsigned WL_PULSE = 2
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              START,
   blwl_config_ctrl_if.slave din_if,
   output logic [0:NUM_BL-1] BL,
   output logic [0:NUM_WL-1] WL,
   output logic              BUSY,
   output logic              DONE
);

   localparam int unsigned RowW   = clog2_min1(NUM_WL);
   localparam int unsigned PulseW = clog2_min1(WL_PULSE + 1);

   state_e              state_q, state_d;
   logic [RowW-1:0]     row_q, row_d;
   logic [PulseW-1:0]   pulse_q, pulse_d;
   logic [0:NUM_WL-1]   wl_q, wl_d;
   logic                ready_q, busy_q, done_q;
   logic                clear;
   logic                beat;
   logic                last_bit;

   bl_row_shifter #(
      .NUM_BL (NUM_BL)
   ) u_bl_row_shifter (
      .clk_i      (CLK),
      .rst_ni     (RSTN),
      .clear_i    (clear),
      .beat_i     (beat),
      .din_i      (din_if.DIN),
      .bl_o       (BL),
      .last_bit_o (last_bit)
   );

   // A beat is consumed only in LOAD, where the registered READY is high.
   assign beat = (state_q == StLoad) && din_if.DIN_VALID;

   // Next-state logic: sequencing, row counter and pulse-width counter.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      pulse_d = '0;
      clear   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (START) begin
               row_d   = '0;
               clear   = 1'b1;
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (beat && last_bit) begin
`ifdef BLWL_SETUP_GUARD_EN
               state_d = StSetup;
`else
               state_d = StPulse;
`endif
            end
         end
         StSetup: begin
            state_d = StPulse;
         end
         StPulse: begin
            if (pulse_q == PulseW'(WL_PULSE - 1)) begin
               state_d = StHold;
            end else begin
               pulse_d = pulse_q + PulseW'(1);
            end
         end
         StHold: begin
            if (row_q == RowW'(NUM_WL - 1)) begin
               state_d = StFinish;
            end else begin
               row_d   = row_q + RowW'(1);
               state_d = StLoad;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output decode from the next state so every output is a plain register.
   always_comb begin
      wl_d = '0;
      if (state_d == StPulse) begin
         wl_d[row_d] = 1'b1;
      end
   end

   // State, counters and registered outputs; reset drops WL in the same edge.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q <= StIdle;
         row_q   <= '0;
         pulse_q <= '0;
         wl_q    <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         pulse_q <= pulse_d;
         wl_q    <= wl_d;
         ready_q <= (state_d == StLoad);
         busy_q  <= (state_d != StIdle);
         done_q  <= (state_d == StFinish);
      end
   end

   assign WL               = wl_q;
   assign BUSY             = busy_q;
   assign DONE             = done_q;
   assign din_if.DIN_READY = ready_q;

endmodule
